// File: rtl/reg_lock_bank.sv
// Register bank with per-register write locks, write-once registers and a saturating
// violation counter. Define REG_LOCK_UNLOCK_EN to build in the two-key unlock sequence.
module reg_lock_bank #(
  parameter int              WIDTH   = 16,
  parameter int              DEPTH   = 4,
  parameter int              ADDR_W  = 2,
  parameter logic [DEPTH-1:0] WO_MASK = DEPTH'(1),
  parameter int              KEY1    = 'hC5,
  parameter int              KEY2    = 'h3A,
  parameter int              TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              ip_resetn,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  Data_in,
  input  logic              lock_req,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  Data_out,
  output logic              rd_valid,
  output logic [DEPTH-1:0]  lock_status,
  output logic              wr_err,
  output logic [7:0]        viol_cnt,
  input  logic              unlock_valid,
  input  logic [WIDTH-1:0]  unlock_key,
  input  logic [ADDR_W-1:0] unlock_addr
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] lock_q, lock_d;
  logic [DEPTH-1:0] wr_sel, wr_acc, unlock_clr;
  logic [WIDTH-1:0] dout_q, rd_data;
  logic             rvld_q, err_q, wr_rej;
  logic [7:0]       viol_q, viol_d;

  // Address decode; out-of-range addresses match no register and are rejected.
  always_comb begin
    wr_sel  = '0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = write && (addr == ADDR_W'(i));
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
    wr_acc = wr_sel & ~lock_q;
    wr_rej = write && (wr_acc == '0);
    lock_d = (lock_q | (wr_acc & (lock_req ? {DEPTH{1'b1}} : WO_MASK))) & ~unlock_clr;
    viol_d = (wr_rej && (viol_q != 8'hFF)) ? viol_q + 8'd1 : viol_q;
  end

  always_ff @(posedge Clk) begin
    if (!ip_resetn) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      lock_q <= '0;
      dout_q <= '0;
      rvld_q <= 1'b0;
      err_q  <= 1'b0;
      viol_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_acc[i]) regs_q[i] <= Data_in;
      lock_q <= lock_d;
      if (read) dout_q <= rd_data;
      rvld_q <= read;
      err_q  <= wr_rej;
      viol_q <= viol_d;
    end
  end

`ifdef REG_LOCK_UNLOCK_EN
  localparam int               CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WIDTH-1:0] KEY1_W = WIDTH'(KEY1);
  localparam logic [WIDTH-1:0] KEY2_W = WIDTH'(KEY2);

  typedef enum logic {IDLE, KEY1_OK} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Any beat seen while armed ends the sequence; only idle cycles count toward timeout.
  always_ff @(posedge Clk) begin
    if (!ip_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (unlock_valid && (unlock_key == KEY1_W)) begin
            state_q <= KEY1_OK;
            cnt_q   <= '0;
          end
        end
        KEY1_OK: begin
          if (unlock_valid || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    unlock_clr = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((state_q == KEY1_OK) && unlock_valid && (unlock_key == KEY2_W) &&
          (unlock_addr == ADDR_W'(i)))
        unlock_clr[i] = 1'b1;
  end
`else
  logic unused_unlock;
  assign unused_unlock = ^{unlock_valid, unlock_key, unlock_addr};
  assign unlock_clr    = '0;
`endif

  assign Data_out    = dout_q;
  assign rd_valid    = rvld_q;
  assign lock_status = lock_q;
  assign wr_err      = err_q;
  assign viol_cnt    = viol_q;

endmodule

// File: tb/tb_reg_lock_bank.sv
// Directed bench for reg_lock_bank with a cycle-level reference model of the bank rules.
module tb_reg_lock_bank;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam logic [3:0]  WO = 4'b0001;
  localparam logic [15:0] K1 = 16'h00C5;
  localparam logic [15:0] K2 = 16'h003A;

  logic        Clk = 1'b0;
  logic        ip_resetn, write, lock_req, read, unlock_valid;
  logic [1:0]  addr, rd_addr, unlock_addr;
  logic [15:0] Data_in, unlock_key, Data_out;
  logic        rd_valid, wr_err;
  logic [3:0]  lock_status;
  logic [7:0]  viol_cnt;

  int checks = 0;
  int errors = 0;

  reg_lock_bank dut (
    .Clk(Clk), .ip_resetn(ip_resetn), .write(write), .addr(addr), .Data_in(Data_in),
    .lock_req(lock_req), .read(read), .rd_addr(rd_addr), .Data_out(Data_out),
    .rd_valid(rd_valid), .lock_status(lock_status), .wr_err(wr_err), .viol_cnt(viol_cnt),
    .unlock_valid(unlock_valid), .unlock_key(unlock_key), .unlock_addr(unlock_addr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state of the bank as the rules describe it.
  logic [15:0] mreg [DEPTH];
  logic [3:0]  mlock;
  int          mviol;
  logic [15:0] mdout;
  bit          mrv, merr, minit, marmed, mrej;
  int          cyc = 0, marm_cyc = 0, ma;

  always @(posedge Clk) begin
    cyc++;
    if (!ip_resetn) begin
      for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
      mlock = '0; mviol = 0; mdout = '0; mrv = 0; merr = 0; marmed = 0; minit = 1;
    end else begin
      mrv = read;
      if (read) mdout = (int'(rd_addr) < DEPTH) ? mreg[rd_addr] : 16'h0;
      ma = int'(addr);
      mrej = write && ((ma >= DEPTH) || mlock[ma]);
      if (write && !mrej) begin
        mreg[ma] = Data_in;
        if (lock_req || WO[ma]) mlock[ma] = 1'b1;
      end
      merr = mrej;
      if (mrej && mviol < 255) mviol++;
`ifdef REG_LOCK_UNLOCK_EN
      if (unlock_valid) begin
        if (marmed && (cyc - marm_cyc) <= TIMEOUT) begin
          if (unlock_key == K2 && int'(unlock_addr) < DEPTH) mlock[unlock_addr] = 1'b0;
          marmed = 0;
        end else if (unlock_key == K1) begin
          marmed = 1; marm_cyc = cyc;
        end else begin
          marmed = 0;
        end
      end
`endif
    end
  end

  always @(negedge Clk) begin
    if (minit) begin
      chk("m_dout", 32'(Data_out), 32'(mdout));
      chk("m_rvld", 32'(rd_valid), 32'(mrv));
      chk("m_lock", 32'(lock_status), 32'(mlock));
      chk("m_err",  32'(wr_err), 32'(merr));
      chk("m_viol", 32'(viol_cnt), 32'(mviol));
    end
  end

  task automatic step();
    @(posedge Clk); #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic lk);
    write = 1; addr = a; Data_in = d; lock_req = lk;
    step();
    write = 0; lock_req = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    read = 1; rd_addr = a;
    step();
    read = 0;
  endtask

  task automatic ub(input logic [15:0] k, input logic [1:0] a);
    unlock_valid = 1; unlock_key = k; unlock_addr = a;
    step();
    unlock_valid = 0;
  endtask

  initial begin
    ip_resetn = 0; write = 1; addr = 2'd1; Data_in = 16'hDEAD; lock_req = 1;
    read = 1; rd_addr = 2'd1; unlock_valid = 0; unlock_key = '0; unlock_addr = '0;
    step(); step();
    chk("rst_dout", 32'(Data_out), 32'h0);
    chk("rst_rvld", 32'(rd_valid), 32'h0);
    chk("rst_lock", 32'(lock_status), 32'h0);
    chk("rst_viol", 32'(viol_cnt), 32'h0);
    ip_resetn = 1; write = 0; read = 0; lock_req = 0;
    step();

    wr(2'd1, 16'h1234, 0);
    rd(2'd1);
    chk("rd1_data", 32'(Data_out), 32'h1234);
    chk("rd1_vld", 32'(rd_valid), 32'h1);
    chk("rd1_lock", 32'(lock_status), 32'h0);
    step();
    chk("rd_hold", 32'(Data_out), 32'h1234);
    chk("rvld_drop", 32'(rd_valid), 32'h0);

    wr(2'd0, 16'h00FF, 0);
    chk("wo_lock", 32'(lock_status), 32'h1);
    wr(2'd0, 16'hAAAA, 0);
    chk("wo_err", 32'(wr_err), 32'h1);
    chk("wo_viol", 32'(viol_cnt), 32'h1);
    rd(2'd0);
    chk("wo_data", 32'(Data_out), 32'h00FF);
    chk("err_drop", 32'(wr_err), 32'h0);

    write = 1; addr = 2'd1; Data_in = 16'h5678; read = 1; rd_addr = 2'd1;
    step();
    write = 0; read = 0;
    chk("rw_old", 32'(Data_out), 32'h1234);
    rd(2'd1);
    chk("rw_new", 32'(Data_out), 32'h5678);

    wr(2'd2, 16'hBEEF, 1);
    chk("lk2_lock", 32'(lock_status), 32'h5);
    for (int i = 0; i < 300; i++) wr(2'd2, 16'(i), 0);
    chk("sat_viol", 32'(viol_cnt), 32'd255);
    rd(2'd2);
    chk("sat_data", 32'(Data_out), 32'hBEEF);

    wr(2'd3, 16'h1111, 1);
    chk("lk3_lock", 32'(lock_status), 32'hD);
`ifdef REG_LOCK_UNLOCK_EN
    ub(K1, 2'd3); ub(K2, 2'd3);
    chk("unl_lock", 32'(lock_status), 32'h5);
    wr(2'd3, 16'h5555, 0);
    chk("unl_err", 32'(wr_err), 32'h0);
    rd(2'd3);
    chk("unl_data", 32'(Data_out), 32'h5555);
    wr(2'd3, 16'h2222, 1);
    ub(K1, 2'd3);
    repeat (TIMEOUT) step();
    ub(K2, 2'd3);
    chk("tmo_lock", 32'(lock_status), 32'hD);
    ub(K1, 2'd3); ub(16'h0000, 2'd3); ub(K2, 2'd3);
    chk("badkey_lock", 32'(lock_status), 32'hD);
    ub(K1, 2'd0);
    repeat (TIMEOUT - 1) step();
    ub(K2, 2'd0);
    chk("late_ok", 32'(lock_status), 32'hC);
    wr(2'd0, 16'h0042, 0);
    chk("relock", 32'(lock_status), 32'hD);
    ub(K1, 2'd3);
    unlock_valid = 1; unlock_key = K2; unlock_addr = 2'd3;
    write = 1; addr = 2'd3; Data_in = 16'h9999;
    step();
    unlock_valid = 0; write = 0;
    chk("race_lock", 32'(lock_status), 32'h5);
    chk("race_err", 32'(wr_err), 32'h1);
    rd(2'd3);
    chk("race_data", 32'(Data_out), 32'h2222);
`else
    ub(K1, 2'd3); ub(K2, 2'd3);
    chk("noen_lock", 32'(lock_status), 32'hD);
    wr(2'd3, 16'h5555, 0);
    chk("noen_err", 32'(wr_err), 32'h1);
    rd(2'd3);
    chk("noen_data", 32'(Data_out), 32'h1111);
`endif

    ub(K1, 2'd1);
    ip_resetn = 0; write = 1; addr = 2'd1; Data_in = 16'h7777; read = 1; rd_addr = 2'd1;
    step();
    chk("mrst_dout", 32'(Data_out), 32'h0);
    chk("mrst_rvld", 32'(rd_valid), 32'h0);
    chk("mrst_lock", 32'(lock_status), 32'h0);
    chk("mrst_err", 32'(wr_err), 32'h0);
    chk("mrst_viol", 32'(viol_cnt), 32'h0);
    ip_resetn = 1; write = 0; read = 0;
    ub(K2, 2'd1);
    rd(2'd1);
    chk("mrst_data", 32'(Data_out), 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
